// File: rtl/scica_cordic_vec_iter.sv
`default_nettype none
// ============================================================================
// Module   : scica_cordic_vec_iter
// Purpose  : Iterative vectoring CORDIC, one micro-rotation per clock. Returns
//            gain-compensated magnitude, quadrant, stage directions and an
//            optional angle. Option macro: SCICA_CORDIC_VEC_ROUND_EN (rounded
//            output scaling instead of truncation).
// Revision : 1.0  initial release
// ============================================================================
module scica_cordic_vec_iter #(
    parameter int DATA_WIDTH    = 16,
    parameter int CORDIC_WIDTH  = 22,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     ica_cordic_vec_en,
    input  logic [DATA_WIDTH-1:0]    ica_cordic_vec_xin,
    input  logic [DATA_WIDTH-1:0]    ica_cordic_vec_yin,
    input  logic                     ica_cordic_vec_angle_calc_en,
    output logic                     cordic_vec_busy,
    output logic                     cordic_vec_opvld,
    output logic [DATA_WIDTH-1:0]    cordic_vec_xout,
    output logic [1:0]               cordic_vec_quad_out,
    output logic [CORDIC_STAGES-1:0] cordic_vec_microRot_out,
    output logic                     cordic_vec_microRot_out_start,
    output logic [ANGLE_WIDTH-1:0]   cordic_vec_angle_out
);

    localparam int c_ext_lsb = CORDIC_WIDTH - DATA_WIDTH - 2;
    localparam int c_shift   = 15 + c_ext_lsb;
    localparam int c_cnt_w   = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;
    localparam int c_prod_w  = CORDIC_WIDTH + 16;

    localparam logic [c_cnt_w-1:0]         c_last_stage = c_cnt_w'(CORDIC_STAGES - 1);
    localparam logic signed [c_prod_w-1:0] c_k_wide     = c_prod_w'(19898);
    localparam logic signed [c_prod_w-1:0] c_max_wide   = c_prod_w'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic [DATA_WIDTH-1:0]      c_max_dw     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ANGLE_WIDTH-1:0]     c_pi         = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
`ifdef SCICA_CORDIC_VEC_ROUND_EN
    localparam logic signed [c_prod_w-1:0] c_round      = c_prod_w'(64'd1 << (c_shift - 1));
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_SCALE = 2'd2
    } state_t;

    // atan(2^-i) with +/-pi = +/-2^15, rescaled to ANGLE_WIDTH
    function automatic logic signed [ANGLE_WIDTH-1:0] atan_rom(input int unsigned idx);
        logic [15:0]               v;
        logic [ANGLE_WIDTH+15:0]   wide;
        case (idx)
            0:       v = 16'd8192;
            1:       v = 16'd4836;
            2:       v = 16'd2555;
            3:       v = 16'd1297;
            4:       v = 16'd651;
            5:       v = 16'd326;
            6:       v = 16'd163;
            7:       v = 16'd81;
            8:       v = 16'd41;
            9:       v = 16'd20;
            10:      v = 16'd10;
            11:      v = 16'd5;
            12:      v = 16'd3;
            13:      v = 16'd1;
            14:      v = 16'd1;
            default: v = 16'd0;
        endcase
        wide = (ANGLE_WIDTH+16)'(v);
        wide = (wide << ANGLE_WIDTH) >> 16;
        return ANGLE_WIDTH'(wide);
    endfunction

    state_t                          state_q, state_d;
    logic [c_cnt_w-1:0]              stage_q, stage_d;
    logic signed [CORDIC_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic signed [ANGLE_WIDTH-1:0]   z_q, z_d;
    logic [1:0]                      quad_q, quad_d;
    logic                            ace_q, ace_d;
    logic                            zero_q, zero_d;
    logic                            busy_q, busy_d;
    logic                            opvld_q, opvld_d;
    logic                            start_q, start_d;
    logic [DATA_WIDTH-1:0]           xout_q, xout_d;
    logic [ANGLE_WIDTH-1:0]          angle_q, angle_d;
    logic [CORDIC_STAGES-1:0]        mrot_q, mrot_d;

    logic signed [CORDIC_WIDTH-1:0]  w_x_ext, w_y_ext, w_x_abs, w_y_abs;
    logic signed [CORDIC_WIDTH-1:0]  w_x_sh, w_y_sh;
    logic signed [ANGLE_WIDTH-1:0]   w_atan;
    logic                            w_dir;
    logic signed [c_prod_w-1:0]      w_x_wide, w_prod, w_scaled;
    logic [DATA_WIDTH-1:0]           w_sat;
    logic [ANGLE_WIDTH-1:0]          w_angle;

    // Operand conditioning: magnitude taken at full internal width so -2^(DW-1) cannot wrap
    always_comb begin
        w_x_ext = CORDIC_WIDTH'($signed(ica_cordic_vec_xin));
        w_y_ext = CORDIC_WIDTH'($signed(ica_cordic_vec_yin));
        w_x_abs = w_x_ext[CORDIC_WIDTH-1] ? -w_x_ext : w_x_ext;
        w_y_abs = w_y_ext[CORDIC_WIDTH-1] ? -w_y_ext : w_y_ext;
    end

    always_comb begin
        w_dir  = ~y_q[CORDIC_WIDTH-1];
        w_x_sh = x_q >>> stage_q;
        w_y_sh = y_q >>> stage_q;
        w_atan = atan_rom(32'(stage_q));
    end

    // Gain compensation and clamp; x only grows during vectoring so a negative result is unreachable
    always_comb begin
        w_x_wide = c_prod_w'(x_q);
        w_prod   = w_x_wide * c_k_wide;
`ifdef SCICA_CORDIC_VEC_ROUND_EN
        w_scaled = (w_prod + c_round) >>> c_shift;
`else
        w_scaled = w_prod >>> c_shift;
`endif
        if (w_scaled > c_max_wide) begin
            w_sat = c_max_dw;
        end else if (w_scaled < 0) begin
            w_sat = '0;
        end else begin
            w_sat = w_scaled[DATA_WIDTH-1:0];
        end
    end

    // Fold the first-quadrant angle back to the operand's true quadrant
    always_comb begin
        w_angle = '0;
        if (ace_q && !zero_q) begin
            case (quad_q)
                2'b00:   w_angle = z_q;
                2'b10:   w_angle = c_pi - z_q;
                2'b11:   w_angle = z_q - c_pi;
                default: w_angle = -z_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        quad_d  = quad_q;
        ace_d   = ace_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        opvld_d = 1'b0;
        start_d = 1'b0;
        xout_d  = xout_q;
        angle_d = angle_q;
        mrot_d  = mrot_q;
        case (state_q)
            S_IDLE: begin
                if (ica_cordic_vec_en) begin
                    x_d     = w_x_abs <<< c_ext_lsb;
                    y_d     = w_y_abs <<< c_ext_lsb;
                    z_d     = '0;
                    quad_d  = {ica_cordic_vec_xin[DATA_WIDTH-1], ica_cordic_vec_yin[DATA_WIDTH-1]};
                    ace_d   = ica_cordic_vec_angle_calc_en;
                    zero_d  = (ica_cordic_vec_xin == '0) && (ica_cordic_vec_yin == '0);
                    mrot_d  = '0;
                    stage_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (w_dir) begin
                    x_d = x_q + w_y_sh;
                    y_d = y_q - w_x_sh;
                    z_d = z_q + w_atan;
                end else begin
                    x_d = x_q - w_y_sh;
                    y_d = y_q + w_x_sh;
                    z_d = z_q - w_atan;
                end
                mrot_d[stage_q] = w_dir;
                start_d         = (stage_q == '0);
                if (stage_q == c_last_stage) begin
                    state_d = S_SCALE;
                end else begin
                    stage_d = stage_q + c_cnt_w'(1);
                end
            end
            S_SCALE: begin
                xout_d  = w_sat;
                angle_d = w_angle;
                opvld_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            quad_q  <= '0;
            ace_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            opvld_q <= 1'b0;
            start_q <= 1'b0;
            xout_q  <= '0;
            angle_q <= '0;
            mrot_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            quad_q  <= quad_d;
            ace_q   <= ace_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            opvld_q <= opvld_d;
            start_q <= start_d;
            xout_q  <= xout_d;
            angle_q <= angle_d;
            mrot_q  <= mrot_d;
        end
    end

    assign cordic_vec_busy               = busy_q;
    assign cordic_vec_opvld              = opvld_q;
    assign cordic_vec_xout               = xout_q;
    assign cordic_vec_quad_out           = quad_q;
    assign cordic_vec_microRot_out       = mrot_q;
    assign cordic_vec_microRot_out_start = start_q;
    assign cordic_vec_angle_out          = angle_q;

endmodule
`default_nettype wire

// File: tb/tb_scica_cordic_vec_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_scica_cordic_vec_iter
// Purpose  : Self-checking bench for scica_cordic_vec_iter against an
//            arithmetic CORDIC model with a cycle-age timeline.
// Revision : 1.0  initial release
// ============================================================================
module tb_scica_cordic_vec_iter;

    localparam int NS  = 16;
    localparam int LAT = 18;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        en = 1'b0;
    logic        ace = 1'b0;
    logic [15:0] xin = '0;
    logic [15:0] yin = '0;

    logic          busy, opvld, start;
    logic [15:0]   xout, angle;
    logic [1:0]    quad;
    logic [NS-1:0] mrot;

    always #5 clk = ~clk;

    scica_cordic_vec_iter #(
        .DATA_WIDTH    (16),
        .CORDIC_WIDTH  (22),
        .ANGLE_WIDTH   (16),
        .CORDIC_STAGES (NS)
    ) dut (
        .clk                           (clk),
        .nreset                        (nreset),
        .ica_cordic_vec_en             (en),
        .ica_cordic_vec_xin            (xin),
        .ica_cordic_vec_yin            (yin),
        .ica_cordic_vec_angle_calc_en  (ace),
        .cordic_vec_busy               (busy),
        .cordic_vec_opvld              (opvld),
        .cordic_vec_xout               (xout),
        .cordic_vec_quad_out           (quad),
        .cordic_vec_microRot_out       (mrot),
        .cordic_vec_microRot_out_start (start),
        .cordic_vec_angle_out          (angle)
    );

    int vectors = 0;
    int miscompares = 0;
    int tab [NS];
    bit chk_on = 1'b0;

    // model timeline: age = cycles since the accepting cycle (1000 = idle, nothing pending)
    int            age = 1000;
    logic [15:0]   m_xo = '0, m_xo_prev = '0, m_ang = '0, m_ang_prev = '0;
    logic [1:0]    m_q = '0;
    logic [NS-1:0] m_mr = '0;

    logic [15:0]   r_xo, r_ang;
    logic [1:0]    r_q;
    logic [NS-1:0] r_mr;
    int            r_lat;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
        vectors++;
        if (act < exp - tol || act > exp + tol) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h +/-%0d", name, act, exp, tol);
        end
    endtask

    function automatic void model_op(input logic [15:0] x, input logic [15:0] y, input logic a,
                                     output logic [15:0] xo, output logic [1:0] q,
                                     output logic [15:0] ang, output logic [NS-1:0] mr);
        longint cx, cy, tx, z, p;
        cx = longint'($signed(x));
        cy = longint'($signed(y));
        if (cx < 0) cx = -cx;
        if (cy < 0) cy = -cy;
        cx = cx * 16;
        cy = cy * 16;
        z  = 0;
        for (int i = 0; i < NS; i++) begin
            tx    = cx;
            mr[i] = (cy >= 0);
            if (mr[i]) begin
                cx = cx + (cy >>> i);
                cy = cy - (tx >>> i);
                z  = z + tab[i];
            end else begin
                cx = cx - (cy >>> i);
                cy = cy + (tx >>> i);
                z  = z - tab[i];
            end
        end
        p = cx * 19898;
`ifdef SCICA_CORDIC_VEC_ROUND_EN
        p = p + 262144;
`endif
        p = p >>> 19;
        if (p > 32767) p = 32767;
        else if (p < 0) p = 0;
        xo = p[15:0];
        q  = {x[15], y[15]};
        if (!a || (x == 16'h0 && y == 16'h0)) begin
            z = 0;
        end else begin
            case (q)
                2'b10:   z = 32768 - z;
                2'b11:   z = z - 32768;
                2'b01:   z = -z;
                default: ;
            endcase
        end
        ang = z[15:0];
    endfunction

    // per-cycle compare against the model, then advance the model past the coming edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (!nreset) begin
                    chk("rst_busy", busy, 0);
                    chk("rst_opvld", opvld, 0);
                    chk("rst_start", start, 0);
                    chk("rst_xout", xout, 0);
                    chk("rst_quad", quad, 0);
                    chk("rst_mrot", mrot, 0);
                    chk("rst_angle", angle, 0);
                end else begin
                    chk("busy", busy, (age >= 1 && age <= LAT - 1));
                    chk("opvld", opvld, (age == LAT));
                    chk("start", start, (age == 2));
                    chk("xout", xout, (age >= LAT) ? m_xo : m_xo_prev);
                    chk("angle", angle, (age >= LAT) ? m_ang : m_ang_prev);
                    if (age >= LAT) begin
                        chk("quad", quad, m_q);
                        chk("mrot", mrot, m_mr);
                    end
                end
            end
            if (!nreset) begin
                age = 1000;
                m_xo = '0; m_xo_prev = '0; m_ang = '0; m_ang_prev = '0; m_q = '0; m_mr = '0;
            end else if (age >= LAT && en) begin
                m_xo_prev  = m_xo;
                m_ang_prev = m_ang;
                model_op(xin, yin, ace, m_xo, m_q, m_ang, m_mr);
                age = 1;
            end else if (age < 1000) begin
                age++;
            end
        end
    end

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic a);
        @(posedge clk); #1;
        en = 1'b1; xin = x; yin = y; ace = a;
        @(posedge clk); #1;
        en = 1'b0;
        r_lat = -1;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (opvld) begin
                r_lat = c; r_xo = xout; r_q = quad; r_ang = angle; r_mr = mrot;
                break;
            end
        end
        if (r_lat < 0) begin
            miscompares++;
            vectors++;
            $display("FAIL op_timeout: no opvld within 40 cycles for x=0x%0h y=0x%0h", x, y);
        end
    endtask

    logic [15:0]   e_xo, e_ang;
    logic [1:0]    e_q;
    logic [NS-1:0] e_mr;
    int            pulses, p1, p2;

    initial begin
        for (int i = 0; i < NS; i++)
            tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) / (4.0 * $atan(1.0)) * 32768.0 + 0.5);

        repeat (3) @(posedge clk);
        #1 chk_on = 1'b1;
        @(posedge clk); #1 nreset = 1'b1;

        // hand-computed pins on the model itself
        chk("tab0", tab[0], 8192);
        chk("tab1", tab[1], 4836);
        model_op(16'h0C00, 16'h1000, 1'b0, e_xo, e_q, e_ang, e_mr);
        chk_tol("model_34_xout", e_xo, 16'h1400, 2);
        model_op(16'h0000, 16'h0000, 1'b1, e_xo, e_q, e_ang, e_mr);
        chk("model_zero_mr", e_mr, 16'hFFFF);

        // (3,4) and (-3,4)
        model_op(16'h0C00, 16'h1000, 1'b0, e_xo, e_q, e_ang, e_mr);
        run_op(16'h0C00, 16'h1000, 1'b0);
        chk("t1_latency", r_lat, LAT);
        chk_tol("t1_xout", r_xo, 16'h1400, 2);
        chk("t1_quad", r_q, 2'b00);
        chk("t1_angle", r_ang, 0);
        chk("t1_mrot", r_mr, e_mr);
        run_op(16'hF400, 16'h1000, 1'b0);
        chk_tol("t2_xout", r_xo, 16'h1400, 2);
        chk("t2_quad", r_q, 2'b10);
        chk("t2_mrot", r_mr, e_mr);

        // 45 degrees in each quadrant
        run_op(16'h0400, 16'h0400, 1'b1);
        chk_tol("t3_angle_q00", r_ang, 16'h2000, 8);
        run_op(16'hFC00, 16'hFC00, 1'b1);
        chk("t3_quad11", r_q, 2'b11);
        chk_tol("t3_angle_q11", r_ang, 16'hA000, 8);
        run_op(16'hFC00, 16'h0400, 1'b1);
        chk_tol("t3_angle_q10", r_ang, 16'h6000, 8);
        run_op(16'h0400, 16'hFC00, 1'b1);
        chk_tol("t3_angle_q01", r_ang, 16'hE000, 8);

        // saturation and extremes
        run_op(16'h7FFF, 16'h7FFF, 1'b0);
        chk("t4_sat", r_xo, 16'h7FFF);
        run_op(16'h8000, 16'h0000, 1'b0);
        chk_tol("t4_minx", r_xo, 16'h7FFF, 2);
        run_op(16'h8000, 16'h8000, 1'b1);
        chk("t4_minxy_sat", r_xo, 16'h7FFF);
        run_op(16'h0000, 16'h0000, 1'b1);
        chk("t4_zero_xout", r_xo, 0);
        chk("t4_zero_quad", r_q, 0);
        chk("t4_zero_mrot", r_mr, 16'hFFFF);
        chk("t4_zero_angle", r_ang, 0);

        // en held high: one acceptance per STAGES+2 cycles
        pulses = 0; p1 = -1; p2 = -1;
        @(posedge clk); #1;
        en = 1'b1; xin = 16'h0C00; yin = 16'h1000; ace = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (opvld) begin
                pulses++;
                if (p1 < 0) p1 = c; else p2 = c;
            end
            if (c < 39) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1 en = 1'b0;
        chk("t5_pulses", pulses, 2);
        chk("t5_first", p1, 18);
        chk("t5_second", p2, 36);
        repeat (20) @(posedge clk);

        // reset in the middle of an operation
        @(posedge clk); #1;
        en = 1'b1; xin = 16'h1234; yin = 16'hE000; ace = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        repeat (7) @(posedge clk);
        #1 nreset = 1'b0;
        @(negedge clk);
        chk("t6_xout_zero", xout, 0);
        chk("t6_busy_zero", busy, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 nreset = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (opvld) pulses++;
        end
        chk("t6_no_opvld", pulses, 0);
        model_op(16'h1234, 16'hE000, 1'b1, e_xo, e_q, e_ang, e_mr);
        run_op(16'h1234, 16'hE000, 1'b1);
        chk("t6_latency", r_lat, LAT);
        chk("t6_xout", r_xo, e_xo);
        chk("t6_angle", r_ang, e_ang);

        // randomized traffic, including requests while busy
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            en  = ($urandom_range(0, 3) == 0);
            ace = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       xin = 16'h8000;
                1:       xin = 16'h7FFF;
                2:       xin = 16'h0000;
                default: xin = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       yin = 16'h8000;
                1:       yin = 16'h0000;
                default: yin = 16'($urandom);
            endcase
        end
        @(posedge clk); #1 en = 1'b0;
        repeat (25) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
